sr_cmd_debounce: RTL and testbench

Front-end stage feeding the behavioural SR latch: converts two raw, asynchronous push-button inputs (set, reset) into clean, single-cycle S and R command pulses. Each input is synchronised, debounced, and rising-edge detected. Arbitration guarantees the latch never sees S=R=1. Simultaneous requests are dropped and flagged instead.

---
 rtl/sr_cmd_debounce_pkg.sv | 27 ++
 rtl/sr_cmd_debounce_chan.sv | 65 ++++++
 rtl/sr_cmd_debounce.sv | 73 +++++++
 tb/tb_sr_cmd_debounce.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sr_cmd_debounce_pkg.sv
// Shared types and constants for the SR latch command front end.
package sr_pkg;

    localparam int DEBOUNCE_DEFAULT = 4;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_SET,
        CMD_RESET,
        CMD_CONFLICT
    } sr_cmd_t;

    // Coincident edges are dropped and reported, so the latch never sees S=R=1.
    function automatic sr_cmd_t arbitrate(input logic set_rise, input logic reset_rise);
        sr_cmd_t cmd;
        cmd = CMD_NONE;
        if (set_rise && reset_rise) begin
            cmd = CMD_CONFLICT;
        end else if (set_rise) begin
            cmd = CMD_SET;
        end else if (reset_rise) begin
            cmd = CMD_RESET;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/sr_cmd_debounce_chan.sv
// One button channel: 2-flop synchroniser, debounce counter, debounced
// level and previous-level register; rise is a combinational rising edge
// of the debounced level.
module debounce_chan
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    // Last count value before the level is allowed to flip.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt_p2;
    logic             level_p2;
    logic             prev_p3;

    // Synchroniser: raw is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // --- stage boundary: synchronised sample -> debounced level ---
    // Count consecutive differing samples; flip the level when the count
    // would reach DEBOUNCE_CYCLES, so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p2   <= '0;
            level_p2 <= 1'b0;
        end else if (sync_p1 == level_p2) begin
            cnt_p2 <= '0;
        end else if (cnt_p2 == CNT_LAST) begin
            cnt_p2   <= '0;
            level_p2 <= sync_p1;
        end else begin
            cnt_p2 <= cnt_p2 + CNT_W'(1);
        end
    end

    // --- stage boundary: debounced level -> edge detect ---
    // Previous debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_p3 <= 1'b0;
        end else begin
            prev_p3 <= level_p2;
        end
    end

    assign rise = level_p2 & ~prev_p3;

endmodule

// File: rtl/sr_cmd_debounce.sv
// Converts raw set/reset buttons into clean single-cycle S/R pulses for a
// level-sensitive SR latch; simultaneous edges are dropped and flagged.
module sr_cmd_debounce
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic reset_btn,
    output logic S,
    output logic R,
    output logic conflict
);

    logic    set_rise;
    logic    reset_rise;
    sr_cmd_t cmd;
    logic    s_nxt;
    logic    r_nxt;
    logic    conflict_nxt;

    debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (set_btn),
        .rise  (set_rise)
    );

    debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reset_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (reset_btn),
        .rise  (reset_rise)
    );

    // Arbitrate the two edges into one command and decode it.
    always_comb begin
        s_nxt        = 1'b0;
        r_nxt        = 1'b0;
        conflict_nxt = 1'b0;
        cmd          = arbitrate(set_rise, reset_rise);
        case (cmd)
            CMD_SET:      s_nxt        = 1'b1;
            CMD_RESET:    r_nxt        = 1'b1;
            CMD_CONFLICT: conflict_nxt = 1'b1;
            default:      ;
        endcase
    end

    // --- stage boundary: arbitration -> registered outputs ---
    // Output registers so the latch sees glitch-free pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            S        <= s_nxt;
            R        <= r_nxt;
            conflict <= conflict_nxt;
        end
    end

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Directed bench for sr_cmd_debounce with DEBOUNCE_CYCLES = 4.
module tb_sr_cmd_debounce;
    import sr_pkg::*;

    logic clk;
    logic rst_n;
    logic set_btn;
    logic reset_btn;
    logic S;
    logic R;
    logic conflict;

    int checks;
    int failures;

    sr_cmd_debounce #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_btn   (set_btn),
        .reset_btn (reset_btn),
        .S         (S),
        .R         (R),
        .conflict  (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {S,R,conflict} for a command.
    function automatic logic [2:0] cmd_vec(input sr_cmd_t c);
        logic [2:0] v;
        v = 3'b000;
        case (c)
            CMD_SET:      v = 3'b100;
            CMD_RESET:    v = 3'b010;
            CMD_CONFLICT: v = 3'b001;
            default:      v = 3'b000;
        endcase
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge and check the outputs 1 ns later.
    task automatic cycle_check(input string tag, input sr_cmd_t exp);
        @(posedge clk);
        #1;
        check_eq(tag, {S, R, conflict}, cmd_vec(exp));
    endtask

    // Mid-cycle asynchronous reset; returns 1 ns after a posedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {S, R, conflict}, 3'b000);
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int bounce [5];
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        bounce    = '{1, 0, 1, 1, 0};

        // Reset with idle buttons: quiet for 20 cycles.
        #3;
        do_reset();
        for (int k = 0; k < 20; k++) cycle_check("idle", CMD_NONE);

        // Held set: one pulse after edge 6, none for the next 50 cycles.
        set_btn = 1'b1;
        for (int k = 0; k <= 56; k++)
            cycle_check("hold_set", (k == 6) ? CMD_SET : CMD_NONE);
        do_reset();

        // Bounce shorter than the debounce window gives nothing.
        for (int i = 0; i < 5; i++) begin
            set_btn = bounce[i][0];
            cycle_check("bounce", CMD_NONE);
        end
        set_btn = 1'b0;
        for (int k = 0; k < 10; k++) cycle_check("bounce_low", CMD_NONE);
        set_btn = 1'b1;
        for (int k = 0; k <= 15; k++)
            cycle_check("after_bounce", (k == 6) ? CMD_SET : CMD_NONE);
        do_reset();

        // Coincident rises: conflict only.
        set_btn   = 1'b1;
        reset_btn = 1'b1;
        for (int k = 0; k <= 15; k++)
            cycle_check("coincide", (k == 6) ? CMD_CONFLICT : CMD_NONE);
        do_reset();

        // Reset one cycle behind set: two separate pulses.
        set_btn = 1'b1;
        cycle_check("stagger", CMD_NONE);
        reset_btn = 1'b1;
        for (int k = 1; k <= 15; k++)
            cycle_check("stagger", (k == 6) ? CMD_SET : (k == 7) ? CMD_RESET : CMD_NONE);
        do_reset();

        // Reset during a pending press; held button is a new press after release.
        set_btn = 1'b1;
        for (int k = 0; k <= 4; k++) cycle_check("pre_rst", CMD_NONE);
        rst_n = 1'b0;
        for (int k = 5; k <= 10; k++) cycle_check("in_rst", CMD_NONE);
        rst_n = 1'b1;
        for (int j = 1; j <= 20; j++)
            cycle_check("post_rst", (j == 7) ? CMD_SET : CMD_NONE);
        do_reset();

        // Asynchronous reset clears a pulse already on the output.
        set_btn = 1'b1;
        for (int k = 0; k <= 6; k++)
            cycle_check("pulse_pre", (k == 6) ? CMD_SET : CMD_NONE);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("pulse_clear", {S, R, conflict}, 3'b000);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
